// File: rtl/dram_ctrl_if.sv
// Command, response and data-RAM signal bundle for dram_ctrl.
// The master side is the command source plus the RAM; the slave side is the controller.
interface dram_ctrl_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [6:0] cmd_addr;
    logic [6:0] cmd_len;
    logic [7:0] cmd_data;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       rsp_err;
    logic       rsp_carry;
    logic [6:0] mem_address;
    logic       mem_we;
    logic       mem_re;
    logic [7:0] mem_din;
    logic [7:0] mem_dout;

    modport master (
        output cmd_valid, cmd_op, cmd_addr, cmd_len, cmd_data, mem_dout,
        input  cmd_ready, rsp_valid, rsp_data, rsp_err, rsp_carry,
               mem_address, mem_we, mem_re, mem_din
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_addr, cmd_len, cmd_data, mem_dout,
        output cmd_ready, rsp_valid, rsp_data, rsp_err, rsp_carry,
               mem_address, mem_we, mem_re, mem_din
    );
endinterface

// File: rtl/dram_ctrl.sv
// Command-driven controller for a single-port data RAM with registered read data:
// READ, WRITE, INCR (read-modify-write +1) and bounded FILL.
module dram_ctrl #(
    parameter int DEPTH = 70
) (
    input  logic       clk,
    input  logic       reset_n,
    dram_ctrl_if.slave bus
);
    // state  | meaning
    // IDLE   | cmd_ready high, waiting for a command
    // RD     | READ: mem_re at the command address
    // RDCAP  | READ: mem_dout valid, captured into rsp_data
    // INC_RD | INCR: mem_re at the command address
    // INC_WR | INCR: write back mem_dout+1
    // WR     | WRITE: single write cycle
    // FILL   | FILL: one write per cycle, address stepping up
    // RSP    | one-cycle rsp_valid, then IDLE

    localparam logic [7:0] DEPTH_W   = 8'(DEPTH);
    localparam logic [6:0] LAST_ADDR = 7'(DEPTH - 1);

    typedef enum logic [2:0] {
        IDLE, RD, RDCAP, INC_RD, INC_WR, WR, FILL, RSP
    } state_t;

    state_t     state, state_nx;
    logic [6:0] addr_q, addr_nx;
    logic [6:0] cnt_q, cnt_nx;
    logic [7:0] din_q, din_nx;
    logic [7:0] rdata_q, rdata_nx;
    logic       err_q, err_nx;
    logic       carry_q, carry_nx;
    logic [7:0] inc_val;

    assign inc_val = bus.mem_dout + 8'd1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            addr_q  <= '0;
            cnt_q   <= '0;
            din_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            carry_q <= 1'b0;
        end else begin
            state   <= state_nx;
            addr_q  <= addr_nx;
            cnt_q   <= cnt_nx;
            din_q   <= din_nx;
            rdata_q <= rdata_nx;
            err_q   <= err_nx;
            carry_q <= carry_nx;
        end
    end

    always_comb begin
        state_nx = state;
        addr_nx  = addr_q;
        cnt_nx   = cnt_q;
        din_nx   = din_q;
        rdata_nx = rdata_q;
        err_nx   = err_q;
        carry_nx = carry_q;
        case (state)
            IDLE: begin
                if (bus.cmd_valid) begin
                    if ({1'b0, bus.cmd_addr} >= DEPTH_W) begin
                        // out-of-range start: respond straight away, RAM untouched
                        state_nx = RSP;
                        rdata_nx = '0;
                        err_nx   = 1'b1;
                        carry_nx = 1'b0;
                    end else begin
                        addr_nx = bus.cmd_addr;
                        cnt_nx  = bus.cmd_len;
                        case (bus.cmd_op)
                            2'b00: state_nx = RD;
                            2'b01: begin
                                state_nx = WR;
                                din_nx   = bus.cmd_data;
                            end
                            2'b10: state_nx = INC_RD;
                            default: begin
                                state_nx = FILL;
                                din_nx   = bus.cmd_data;
                            end
                        endcase
                    end
                end
            end
            RD:     state_nx = RDCAP;
            RDCAP: begin
                state_nx = RSP;
                rdata_nx = bus.mem_dout;
                err_nx   = 1'b0;
                carry_nx = 1'b0;
            end
            INC_RD: state_nx = INC_WR;
            INC_WR: begin
                state_nx = RSP;
                din_nx   = inc_val;
                rdata_nx = inc_val;
                err_nx   = 1'b0;
                carry_nx = (bus.mem_dout == 8'hFF);
            end
            WR: begin
                state_nx = RSP;
                rdata_nx = '0;
                err_nx   = 1'b0;
                carry_nx = 1'b0;
            end
            FILL: begin
                if (cnt_q == 7'd0) begin
                    state_nx = RSP;
                    rdata_nx = '0;
                    err_nx   = 1'b0;
                    carry_nx = 1'b0;
                end else if (addr_q == LAST_ADDR) begin
                    // words still pending but the top of memory was just written
                    state_nx = RSP;
                    rdata_nx = '0;
                    err_nx   = 1'b1;
                    carry_nx = 1'b0;
                end else begin
                    addr_nx = addr_q + 7'd1;
                    cnt_nx  = cnt_q - 7'd1;
                end
            end
            RSP:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign bus.cmd_ready   = (state == IDLE);
    assign bus.rsp_valid   = (state == RSP);
    assign bus.rsp_data    = rdata_q;
    assign bus.rsp_err     = err_q;
    assign bus.rsp_carry   = carry_q;
    assign bus.mem_address = addr_q;
    assign bus.mem_re      = (state == RD) || (state == INC_RD);
    assign bus.mem_we      = (state == WR) || (state == FILL) || (state == INC_WR);
    // the incremented word is only known once the RAM read data arrives in INC_WR
    assign bus.mem_din     = (state == INC_WR) ? inc_val : din_q;
endmodule

// File: tb/tb_dram_ctrl.sv
// Self-checking bench for dram_ctrl: directed vector table, reset abort sequence and a
// random command stream against a word-level memory model.
module tb_dram_ctrl;
    localparam int DEPTH = 70;

    logic clk = 1'b0;
    logic reset_n = 1'b1;
    dram_ctrl_if bus ();

    dram_ctrl #(.DEPTH(DEPTH)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    logic [7:0] ram [0:127];
    always @(posedge clk) begin
        if (bus.mem_we) ram[bus.mem_address] <= bus.mem_din;
        if (bus.mem_re) bus.mem_dout <= ram[bus.mem_address];
    end

    int n_cmp = 0;
    int n_bad = 0;
    int n_overlap = 0;
    int ref_mem [0:127];

    always @(negedge clk) begin
        if (bus.mem_we && bus.mem_re) n_overlap++;
        if ((bus.cmd_ready || bus.rsp_valid) && (bus.mem_we || bus.mem_re)) n_overlap++;
    end

    typedef struct {
        int data, err, carry, cycles, nwr, nrd, wr_base, wr_val, wr_cyc0;
    } exp_t;

    typedef struct {
        logic [1:0] op;
        int addr, len, dat;
        int exp_data, exp_err, exp_carry, exp_cycles, exp_nwr;
    } vec_t;

    task automatic chk(input string name, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Word-level model: what each command does to memory and what it answers.
    function automatic exp_t ref_cmd(input logic [1:0] op, input int a, input int len, input int d);
        exp_t e;
        int n;
        e = '{default: 0};
        e.wr_base = a;
        if (a >= DEPTH) begin
            e.err = 1;
            e.cycles = 1;
            return e;
        end
        case (op)
            2'd0: begin
                e.data = ref_mem[a]; e.cycles = 3; e.nrd = 1;
            end
            2'd1: begin
                ref_mem[a] = d; e.cycles = 2; e.nwr = 1; e.wr_val = d; e.wr_cyc0 = 1;
            end
            2'd2: begin
                e.data = (ref_mem[a] + 1) % 256;
                e.carry = (ref_mem[a] == 255) ? 1 : 0;
                ref_mem[a] = e.data;
                e.cycles = 3; e.nrd = 1; e.nwr = 1; e.wr_val = e.data; e.wr_cyc0 = 2;
            end
            default: begin
                n = (len + 1 < DEPTH - a) ? len + 1 : DEPTH - a;
                e.err = (len + 1 > DEPTH - a) ? 1 : 0;
                for (int i = 0; i < n; i++) ref_mem[a + i] = d;
                e.cycles = n + 1; e.nwr = n; e.wr_val = d; e.wr_cyc0 = 1;
            end
        endcase
        return e;
    endfunction

    task automatic drive_cmd(input logic [1:0] op, input int a, input int len, input int d);
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_addr  = 7'(a);
        bus.cmd_len   = 7'(len);
        bus.cmd_data  = 8'(d);
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'($urandom);
        bus.cmd_addr  = 7'($urandom);
        bus.cmd_len   = 7'($urandom);
        bus.cmd_data  = 8'($urandom);
    endtask

    task automatic do_cmd(input string tag, input logic [1:0] op, input int a, input int len,
                          input int d, input exp_t e);
        int wa[$], wd[$], wc[$];
        int n_rd = 0, rd_addr = -1, rd_cyc = -1;
        int cyc = -1, r_data = 0, r_err = 0, r_carry = 0;
        chk({tag, " ready_before"}, int'(bus.cmd_ready), 1);
        drive_cmd(op, a, len, d);
        for (int k = 1; k <= 200; k++) begin
            @(negedge clk);
            if (bus.mem_we) begin
                wa.push_back(int'(bus.mem_address));
                wd.push_back(int'(bus.mem_din));
                wc.push_back(k);
            end
            if (bus.mem_re) begin
                n_rd++; rd_addr = int'(bus.mem_address); rd_cyc = k;
            end
            if (bus.rsp_valid) begin
                cyc = k; r_data = int'(bus.rsp_data);
                r_err = int'(bus.rsp_err); r_carry = int'(bus.rsp_carry);
                break;
            end
        end
        chk({tag, " rsp_cycle"}, cyc, e.cycles);
        chk({tag, " rsp_data"}, r_data, e.data);
        chk({tag, " rsp_err"}, r_err, e.err);
        chk({tag, " rsp_carry"}, r_carry, e.carry);
        chk({tag, " n_writes"}, wa.size(), e.nwr);
        for (int i = 0; i < wa.size() && i < e.nwr; i++) begin
            chk({tag, " wr_addr"}, wa[i], e.wr_base + i);
            chk({tag, " wr_data"}, wd[i], e.wr_val);
            chk({tag, " wr_cycle"}, wc[i], e.wr_cyc0 + i);
        end
        chk({tag, " n_reads"}, n_rd, e.nrd);
        if (n_rd > 0 && e.nrd > 0) begin
            chk({tag, " rd_addr"}, rd_addr, a);
            chk({tag, " rd_cycle"}, rd_cyc, 1);
        end
        @(negedge clk);
        chk({tag, " ready_after"}, int'(bus.cmd_ready), 1);
        chk({tag, " rsp_pulse"}, int'(bus.rsp_valid), 0);
    endtask

    vec_t tbl [18];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        int bad;
        logic [1:0] op;
        int a, len, d;

        tbl[0]  = '{2'd1, 'h20, 0, 'h5A,  0,    0, 0, 2, 1};
        tbl[1]  = '{2'd0, 'h20, 0, 0,     'h5A, 0, 0, 3, 0};
        tbl[2]  = '{2'd1, 'h22, 0, 'hFF,  0,    0, 0, 2, 1};
        tbl[3]  = '{2'd2, 'h22, 0, 0,     'h00, 0, 1, 3, 1};
        tbl[4]  = '{2'd0, 'h22, 0, 0,     'h00, 0, 0, 3, 0};
        tbl[5]  = '{2'd1, 'h44, 0, 'h11,  0,    0, 0, 2, 1};
        tbl[6]  = '{2'd3, 'h40, 3, 'hA5,  0,    0, 0, 5, 4};
        tbl[7]  = '{2'd0, 'h43, 0, 0,     'hA5, 0, 0, 3, 0};
        tbl[8]  = '{2'd0, 'h44, 0, 0,     'h11, 0, 0, 3, 0};
        tbl[9]  = '{2'd3, 67,   9, 'h3C,  0,    1, 0, 4, 3};
        tbl[10] = '{2'd0, 80,   0, 0,     0,    1, 0, 1, 0};
        tbl[11] = '{2'd0, 69,   0, 0,     'h3C, 0, 0, 3, 0};
        tbl[12] = '{2'd1, 'h10, 0, 'h7F,  0,    0, 0, 2, 1};
        tbl[13] = '{2'd2, 'h10, 0, 0,     'h80, 0, 0, 3, 1};
        tbl[14] = '{2'd3, 0,    0, 'h99,  0,    0, 0, 2, 1};
        tbl[15] = '{2'd3, 69,   0, 'h42,  0,    0, 0, 2, 1};
        tbl[16] = '{2'd1, 70,   0, 'h55,  0,    1, 0, 1, 0};
        tbl[17] = '{2'd0, 0,    0, 0,     'h99, 0, 0, 3, 0};

        for (int i = 0; i < 128; i++) begin
            ram[i] = 8'h00;
            ref_mem[i] = 0;
        end
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'd0;
        bus.cmd_addr  = 7'd0;
        bus.cmd_len   = 7'd0;
        bus.cmd_data  = 8'd0;

        #3 reset_n = 1'b0;
        #10;
        chk("reset cmd_ready", int'(bus.cmd_ready), 1);
        chk("reset rsp_valid", int'(bus.rsp_valid), 0);
        chk("reset rsp_err", int'(bus.rsp_err), 0);
        chk("reset rsp_carry", int'(bus.rsp_carry), 0);
        chk("reset rsp_data", int'(bus.rsp_data), 0);
        chk("reset mem_we", int'(bus.mem_we), 0);
        chk("reset mem_re", int'(bus.mem_re), 0);
        chk("reset mem_address", int'(bus.mem_address), 0);
        chk("reset mem_din", int'(bus.mem_din), 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        foreach (tbl[i]) begin
            e = ref_cmd(tbl[i].op, tbl[i].addr, tbl[i].len, tbl[i].dat);
            e.data   = tbl[i].exp_data;
            e.err    = tbl[i].exp_err;
            e.carry  = tbl[i].exp_carry;
            e.cycles = tbl[i].exp_cycles;
            e.nwr    = tbl[i].exp_nwr;
            do_cmd($sformatf("vec%0d", i), tbl[i].op, tbl[i].addr, tbl[i].len, tbl[i].dat, e);
        end

        // Reset in the second FILL cycle: only the first word lands, no response.
        e = ref_cmd(2'd1, 'h09, 0, 'h33);
        do_cmd("rst_pre", 2'd1, 'h09, 0, 'h33, e);
        drive_cmd(2'd3, 'h08, 5, 'h77);
        @(negedge clk);
        chk("rst fill_we_c1", int'(bus.mem_we), 1);
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("rst mem_we_drop", int'(bus.mem_we), 0);
        chk("rst cmd_ready", int'(bus.cmd_ready), 1);
        chk("rst rsp_valid", int'(bus.rsp_valid), 0);
        chk("rst mem_address", int'(bus.mem_address), 0);
        bad = 0;
        repeat (3) begin
            @(negedge clk);
            if (bus.rsp_valid || bus.mem_we || bus.mem_re) bad++;
        end
        reset_n = 1'b1;
        @(negedge clk);
        if (bus.rsp_valid || bus.mem_we || bus.mem_re) bad++;
        chk("rst quiet", bad, 0);
        chk("rst ready_after", int'(bus.cmd_ready), 1);
        ref_mem['h08] = 'h77;
        e = ref_cmd(2'd0, 'h08, 0, 0);
        do_cmd("rst_rd8", 2'd0, 'h08, 0, 0, e);
        e = ref_cmd(2'd0, 'h09, 0, 0);
        do_cmd("rst_rd9", 2'd0, 'h09, 0, 0, e);

        for (int i = 0; i < 80; i++) begin
            op  = 2'($urandom_range(0, 3));
            a   = ($urandom_range(0, 9) == 0) ? int'($urandom_range(70, 127)) : int'($urandom_range(0, 69));
            len = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 127)) : int'($urandom_range(0, 12));
            d   = int'($urandom_range(0, 255));
            if ($urandom_range(0, 5) == 0) d = 255;
            e = ref_cmd(op, a, len, d);
            do_cmd($sformatf("rnd%0d", i), op, a, len, d, e);
        end

        chk("mem_we_re_overlap", n_overlap, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/dram_ctrl.md
DRAM_CTRL -- requirements
Module: dram_ctrl

Interface
REQ-001 The block SHALL have parameter DEPTH, default 70, giving the number of data-memory words; legal addresses are 0..DEPTH-1.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; every register SHALL be clocked on its rising edge.
REQ-003 The block SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port cmd_valid, input, 1 bit: command request.
REQ-005 The block SHALL have port cmd_ready, output, 1 bit: command accepted when high together with cmd_valid.
REQ-006 The block SHALL have port cmd_op, input, 2 bits: 00 READ, 01 WRITE, 10 INCR (read-modify-write +1), 11 FILL.
REQ-007 The block SHALL have port cmd_addr, input, 7 bits: start address.
REQ-008 The block SHALL have port cmd_len, input, 7 bits: FILL word count minus 1; ignored for other ops.
REQ-009 The block SHALL have port cmd_data, input, 8 bits: WRITE/FILL data.
REQ-010 The block SHALL have port rsp_valid, output, 1 bit: one-cycle completion pulse.
REQ-011 The block SHALL have port rsp_data, output, 8 bits: READ data or INCR result; 0 for other ops.
REQ-012 The block SHALL have port rsp_err, output, 1 bit: range error, qualified by rsp_valid.
REQ-013 The block SHALL have port rsp_carry, output, 1 bit: INCR wrapped FF->00, qualified by rsp_valid.
REQ-014 The block SHALL have port mem_address, output, 7 bits: data-RAM address.
REQ-015 The block SHALL have port mem_we, output, 1 bit: data-RAM synchronous write enable.
REQ-016 The block SHALL have port mem_re, output, 1 bit: data-RAM synchronous read enable.
REQ-017 The block SHALL have port mem_din, output, 8 bits: data-RAM write data.
REQ-018 The block SHALL have port mem_dout, input, 8 bits: data-RAM registered read data, valid the cycle after mem_re.

Function
REQ-019 The block SHALL implement the states IDLE, RD, RDCAP, INC_RD, INC_WR, WR, FILL and RSP; all outputs SHALL be decoded from registers.
REQ-020 cmd_ready SHALL be 1 only in IDLE; a command SHALL be accepted on the edge where cmd_valid=1 and cmd_ready=1 (cycle 0).
REQ-021 All command fields SHALL be registered at acceptance; input changes after acceptance SHALL have no effect.
REQ-022 READ: cycle 1 mem_re=1, mem_address=addr; cycle 2 capture mem_dout into rsp_data; cycle 3 rsp_valid=1.
REQ-023 WRITE: cycle 1 mem_we=1, mem_address=addr, mem_din=cmd_data; cycle 2 rsp_valid=1, rsp_data=0.
REQ-024 INCR: cycle 1 mem_re=1; cycle 2 mem_we=1, mem_din=mem_dout+1 modulo 256; cycle 3 rsp_valid=1, rsp_data=new value, rsp_carry=1 iff old value was FF.
REQ-025 FILL: cycles 1..len+1 mem_we=1, mem_din=cmd_data, mem_address=addr+k for k=0..len; cycle len+2 rsp_valid=1.
REQ-026 FILL reaching address DEPTH-1 before len+1 writes SHALL stop after writing DEPTH-1 and respond with rsp_err=1 on the next cycle; it SHALL never wrap to 0.
REQ-027 A command with cmd_addr>=DEPTH SHALL perform no memory access and SHALL give rsp_valid=1, rsp_err=1, rsp_data=0 in cycle 1.
REQ-028 mem_we and mem_re SHALL never both be 1 in the same cycle; both SHALL be 0 in IDLE and RSP.
REQ-029 When not in an access cycle, mem_address, mem_din, rsp_data, rsp_err and rsp_carry SHALL hold their last values; rsp_* SHALL be meaningful only while rsp_valid=1.
REQ-030 The block SHALL return to IDLE in the cycle after rsp_valid, so back-to-back commands are accepted every len+3 / 4 / 4 / 3 cycles (FILL / READ / INCR / WRITE).

Reset
REQ-031 reset_n=0 SHALL immediately force state IDLE, cmd_ready=1, rsp_valid=0, rsp_err=0, rsp_carry=0, rsp_data=0, mem_we=0, mem_re=0, mem_address=0, mem_din=0.
REQ-032 Reset asserted mid-command SHALL abort it with no further memory access and no response; RAM contents already written SHALL be retained.

Verification
REQ-033 WRITE addr 0x20 data 0x5A, then READ 0x20 -> write rsp at cycle 2; read rsp_valid at cycle 3 with rsp_data=0x5A, rsp_err=0.
REQ-034 Preload 0x22=FF; INCR 0x22 -> cycle 2 mem_we=1, mem_din=00; rsp_data=00, rsp_carry=1; a following READ 0x22 returns 00.
REQ-035 FILL addr 0x40 len 3 data 0xA5 -> exactly 4 writes to 0x40..0x43, rsp_valid at cycle 5, rsp_err=0; READ 0x44 is unchanged.
REQ-036 FILL addr 67 len 9 (DEPTH=70) -> writes to 67,68,69 only, then rsp_err=1; READ 0x50 (80) -> rsp_err=1, no mem_re/mem_we.
REQ-037 Assert reset_n=0 during FILL cycle 2 -> mem_we drops immediately, no rsp_valid; after release cmd_ready=1 and a READ of the first address returns the filled data.
REQ-038 Random command stream checked against a reference memory model -> all rsp_data match; mem_we&mem_re is never 1.
